// File: rtl/buffer_wide_to_narrow.sv
// Width-down-converting buffer: wide words are queued in a FIFO and replayed
// one OUT_W lane per accepted cycle, lane 0 first, honouring partial-word lane counts.
module buffer_wide_to_narrow #(
  parameter int IN_W  = 512,
  parameter int OUT_W = 64,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(IN_W / OUT_W) + 1,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CW-1:0]    in_nlanes,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int R  = IN_W / OUT_W;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(R);

  logic [IN_W-1:0] data_mem   [DEPTH];
  logic [CW-1:0]   nlanes_mem [DEPTH];
  logic [DEPTH-1:0] last_mem;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [SW-1:0] sel_q, sel_d;

  logic            push;
  logic            pop;
  logic            lane_take;
  logic            lane_is_final;
  logic [CW-1:0]   in_nlanes_eff;
  logic [IN_W-1:0] head_data;
  logic [CW-1:0]   head_nlanes;
  logic            head_last;

  always_comb begin
    full          = (count_q == LW'(DEPTH));
    empty         = (count_q == '0);
    level         = count_q;
    in_ready      = !full;
    out_valid     = !empty;
    push          = in_valid && !full;
    // A lane count of zero stands for a completely filled word.
    in_nlanes_eff = (in_nlanes == '0) ? CW'(R) : in_nlanes;

    head_data     = data_mem[rd_ptr_q];
    head_nlanes   = nlanes_mem[rd_ptr_q];
    head_last     = last_mem[rd_ptr_q];
    lane_is_final = ({1'b0, sel_q} == (head_nlanes - CW'(1)));

    out_data      = head_data[sel_q*OUT_W +: OUT_W];
    out_last      = out_valid && head_last && lane_is_final;
    lane_take     = out_valid && out_ready;
    pop           = lane_take && lane_is_final;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sel_d    = sel_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase

    if (lane_take) sel_d = pop ? '0 : sel_q + SW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sel_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
    end
  end

  // NOTE: storage is deliberately not reset; emptiness comes from the count, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q]   <= in_data;
      nlanes_mem[wr_ptr_q] <= in_nlanes_eff;
      last_mem[wr_ptr_q]   <= in_last;
    end
  end

endmodule

// File: tb/tb_buffer_wide_to_narrow.sv
// Self-checking bench: a lane-queue reference model predicts every emitted lane,
// the word-level fill level and the flags of buffer_wide_to_narrow.
module tb_buffer_wide_to_narrow;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int DEPTH = 16;
  localparam int R     = IN_W / OUT_W;
  localparam int CW    = $clog2(R) + 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, clr;
  logic [IN_W-1:0]  in_data;
  logic [CW-1:0]    in_nlanes;
  logic             in_last, in_valid, in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last, out_valid, out_ready;
  logic             full, empty;
  logic [LW-1:0]    level;

  buffer_wide_to_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_nlanes(in_nlanes), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .full(full), .empty(empty), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: the flat sequence of lanes still owed to the consumer.
  typedef struct {
    logic [OUT_W-1:0] d;
    bit               last;
    bit               eow;
  } lane_t;

  lane_t exp_q[$];
  int    m_level;
  int    total, bad;

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Advance one clock; the model applies the same handshake rules to pre-edge inputs.
  task automatic tick();
    bit    do_push, do_pop;
    int    n;
    lane_t l;
    do_push = in_valid && (m_level < DEPTH);
    do_pop  = out_ready && (exp_q.size() > 0);
    n       = (in_nlanes == '0) ? R : int'(in_nlanes);
    @(posedge clk);
    #1;
    if (rst || clr) begin
      exp_q.delete();
      m_level = 0;
    end else begin
      if (do_pop) begin
        l = exp_q.pop_front();
        if (l.eow) m_level--;
      end
      if (do_push) begin
        for (int k = 0; k < n; k++) begin
          l.d    = in_data[k*OUT_W +: OUT_W];
          l.last = in_last && (k == n - 1);
          l.eow  = (k == n - 1);
          exp_q.push_back(l);
        end
        m_level++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_nlanes = '0; in_last = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, out_last, empty, full, level} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, LW'(0)}) begin
      bad++;
      $display("FAIL reset_state: got rdy/vld/last/empty/full/level=%b exp %b",
               {in_ready, out_valid, out_last, empty, full, level},
               {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, LW'(0)});
    end
  endtask

  task automatic test_single_word();
    in_data = '0;
    for (int k = 0; k < R; k++) in_data[k*OUT_W +: OUT_W] = OUT_W'(k);
    in_nlanes = '0; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < R; k++) begin
      total++;
      if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, OUT_W'(k)}) begin
        bad++;
        $display("FAIL single_lane%0d: got vld/last/data=%h exp %h", k,
                 {out_valid, out_last, out_data}, {1'b1, 1'b0, OUT_W'(k)});
      end
      tick();
    end
    total++;
    if ({empty, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL single_drained: got empty/vld=%b exp 10", {empty, out_valid});
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0; in_nlanes = '0;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = rand_word(); in_last = 1'($urandom); in_valid = 1'b1;
      tick();
    end
    total++;
    if ({level, full, in_ready} !== {LW'(DEPTH), 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL full_flags: got level/full/rdy=%b exp %b", {level, full, in_ready},
               {LW'(DEPTH), 1'b1, 1'b0});
    end
    in_data = rand_word();
    tick();
    in_valid = 1'b0;
    total++;
    if (level !== LW'(DEPTH)) begin
      bad++;
      $display("FAIL full_reject: got level=%0d exp %0d", level, DEPTH);
    end
    out_ready = 1'b1;
    for (int i = 0; i < R; i++) begin
      total++;
      if (exp_q.size() == 0 || {out_valid, out_last, out_data} !== {1'b1, exp_q[0].last, exp_q[0].d}) begin
        bad++;
        $display("FAIL full_drain_lane%0d: got vld/last/data=%h", i, {out_valid, out_last, out_data});
      end
      tick();
    end
    out_ready = 1'b0;
    total++;
    if ({level, full, in_ready} !== {LW'(DEPTH - 1), 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL full_after_pop: got level/full/rdy=%b exp %b", {level, full, in_ready},
               {LW'(DEPTH - 1), 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      total++;
      if ({out_valid, out_last, out_data} !== {1'b1, exp_q[0].last, exp_q[0].d}) begin
        bad++;
        $display("FAIL full_rest_lane: got vld/last/data=%h exp %h",
                 {out_valid, out_last, out_data}, {1'b1, exp_q[0].last, exp_q[0].d});
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL full_drain_timeout: lanes left=%0d empty=%b exp 0 and 1", exp_q.size(), empty);
    end
  endtask

  task automatic test_partial();
    logic [IN_W-1:0]  a, b;
    logic [OUT_W-1:0] ed;
    bit               el;
    a = rand_word(); b = rand_word();
    out_ready = 1'b1;
    in_data = a; in_nlanes = CW'(3); in_last = 1'b1; in_valid = 1'b1;
    tick();
    for (int j = 0; j < 3 + R; j++) begin
      ed = (j < 3) ? a[j*OUT_W +: OUT_W] : b[(j-3)*OUT_W +: OUT_W];
      el = (j == 2);
      total++;
      if ({out_valid, out_last, out_data} !== {1'b1, el, ed}) begin
        bad++;
        $display("FAIL partial_lane%0d: got vld/last/data=%h exp %h", j,
                 {out_valid, out_last, out_data}, {1'b1, el, ed});
      end
      if (j == 0) begin
        in_data = b; in_nlanes = CW'(R); in_last = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL partial_end: got vld=%b exp 0", out_valid);
    end
  endtask

  task automatic test_random_stream();
    int sent;
    bit acc;
    sent = 0;
    in_data = rand_word(); in_nlanes = CW'($urandom_range(0, R)); in_last = 1'($urandom);
    in_valid = 1'b1;
    for (int c = 0; c < 3000 && (sent < 40 || exp_q.size() > 0); c++) begin
      out_ready = 1'($urandom_range(0, 1));
      total++;
      if ({out_valid, full, empty, in_ready, level} !==
          {exp_q.size() > 0, m_level == DEPTH, m_level == 0, m_level < DEPTH, LW'(m_level)}) begin
        bad++;
        $display("FAIL stream_flags: got vld/full/empty/rdy/level=%b exp %b",
                 {out_valid, full, empty, in_ready, level},
                 {exp_q.size() > 0, m_level == DEPTH, m_level == 0, m_level < DEPTH, LW'(m_level)});
      end
      if (exp_q.size() > 0) begin
        total++;
        if ({out_last, out_data} !== {exp_q[0].last, exp_q[0].d}) begin
          bad++;
          $display("FAIL stream_lane: got last/data=%h exp %h", {out_last, out_data},
                   {exp_q[0].last, exp_q[0].d});
        end
      end
      acc = in_valid && (m_level < DEPTH);
      tick();
      if (acc) begin
        sent++;
        if (sent < 40) begin
          in_data = rand_word(); in_nlanes = CW'($urandom_range(0, R)); in_last = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    total++;
    if (sent != 40 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stream_timeout: sent=%0d lanes left=%0d exp 40 and 0", sent, exp_q.size());
    end
  endtask

  task automatic test_clear();
    logic [IN_W-1:0] w;
    out_ready = 1'b0; in_nlanes = '0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = rand_word(); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    total++;
    if (exp_q.size() == 0 || {level, out_valid, out_data} !== {LW'(5), 1'b1, exp_q[0].d}) begin
      bad++;
      $display("FAIL clear_setup: got level/vld/data=%h", {level, out_valid, out_data});
    end
    clr = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0; out_ready = 1'b0;
    total++;
    if ({out_valid, level, empty} !== {1'b0, LW'(0), 1'b1}) begin
      bad++;
      $display("FAIL clear_state: got vld/level/empty=%b exp %b", {out_valid, level, empty},
               {1'b0, LW'(0), 1'b1});
    end
    w = rand_word();
    in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_data} !== {1'b1, w[OUT_W-1:0]}) begin
      bad++;
      $display("FAIL clear_restart: got vld/data=%h exp %h", {out_valid, out_data}, {1'b1, w[OUT_W-1:0]});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_nlanes = '0;
    for (int c = 0; c < 6 * R + 2; c++) begin
      in_valid = (c % R == 0) && (c < 6 * R);
      if (in_valid) begin
        in_data = rand_word(); in_last = 1'($urandom);
      end
      total++;
      if (level > LW'(1) || level !== LW'(m_level)) begin
        bad++;
        $display("FAIL b2b_level: got level=%0d exp %0d (never above 1)", level, m_level);
      end
      if (exp_q.size() > 0) begin
        total++;
        if ({out_valid, out_last, out_data} !== {1'b1, exp_q[0].last, exp_q[0].d}) begin
          bad++;
          $display("FAIL b2b_lane: got vld/last/data=%h exp %h", {out_valid, out_last, out_data},
                   {1'b1, exp_q[0].last, exp_q[0].d});
        end
      end
      tick();
    end
    in_valid = 1'b0;
    total++;
    if ({empty, level} !== {1'b1, LW'(0)}) begin
      bad++;
      $display("FAIL b2b_end: got empty/level=%b exp %b", {empty, level}, {1'b1, LW'(0)});
    end
  endtask

  initial begin
    total = 0; bad = 0; m_level = 0;
    test_reset();
    test_single_word();
    test_full();
    test_partial();
    test_random_stream();
    test_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
